// File: rtl/gpio_wb_if.sv
// Wishbone slave bus bundle for gpio_wb.
// Handshake: master raises wb_stb_i with adr/we/sel/dat stable; slave answers with a one-cycle wb_ack_o.
interface gpio_wb_if;
    logic [1:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/gpio_wb.sv
// Wishbone-slave GPIO: per-bit output enable, data latch, atomic SET/CLR, registered ack/data.
// Build macro GPIO_INPUT_SYNC_EN puts a 2-flop synchronizer in front of the DATA read path.
module gpio_wb #(
    parameter int N = 8
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    gpio_wb_if.slave     wb,
    inout  wire  [N-1:0] gpio_io
);
    localparam logic [1:0] ADR_DATA = 2'd0;
    localparam logic [1:0] ADR_OE   = 2'd1;
    localparam logic [1:0] ADR_SET  = 2'd2;

    logic [N-1:0] r_latch;
    logic [N-1:0] r_oe;
    logic         r_ack;
    logic [31:0]  r_dat_o;

    logic         w_access;
    logic         w_wr;
    logic         w_rd;
    logic [N-1:0] w_wmask;
    logic [N-1:0] w_wdat;
    logic [N-1:0] w_set_bits;
    logic [N-1:0] w_latch_nxt;
    logic [N-1:0] w_oe_nxt;
    logic [N-1:0] w_pin_in;
    logic [31:0]  w_rd_word;

    // An access fires on an edge with stb high while no ack is outstanding,
    // which gives the one-ack-every-two-cycles rhythm for a held strobe.
    assign w_access = wb.wb_stb_i & ~r_ack;
    assign w_wr     = w_access & wb.wb_we_i;
    assign w_rd     = w_access & ~wb.wb_we_i;

    always_comb begin
        w_wmask = '0;
        w_wdat  = '0;
        for (int i = 0; i < N; i++) begin
            w_wmask[i] = wb.wb_sel_i[i / 8];
            w_wdat[i]  = wb.wb_dat_i[i];
        end
    end

    assign w_set_bits = w_wdat & w_wmask;

    always_comb begin
        w_latch_nxt = r_latch;
        w_oe_nxt    = r_oe;
        if (w_wr) begin
            case (wb.wb_adr_i)
                ADR_DATA: w_latch_nxt = (r_latch & ~w_wmask) | w_set_bits;
                ADR_OE:   w_oe_nxt    = (r_oe & ~w_wmask) | w_set_bits;
                ADR_SET:  w_latch_nxt = r_latch | w_set_bits;
                default:  w_latch_nxt = r_latch & ~w_set_bits;
            endcase
        end
    end

`ifdef GPIO_INPUT_SYNC_EN
    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_io;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pin_in = r_sync2;
`else
    assign w_pin_in = gpio_io;
`endif

    // SET and CLR are write-only strobes and always read back as zero.
    always_comb begin
        w_rd_word = '0;
        case (wb.wb_adr_i)
            ADR_DATA: w_rd_word[N-1:0] = w_pin_in;
            ADR_OE:   w_rd_word[N-1:0] = r_oe;
            default:  w_rd_word        = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_latch <= '0;
            r_oe    <= '0;
            r_ack   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_latch <= w_latch_nxt;
            r_oe    <= w_oe_nxt;
            r_ack   <= w_access;
            if (w_rd) begin
                r_dat_o <= w_rd_word;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pin
        assign gpio_io[g] = r_oe[g] ? r_latch[g] : 1'bz;
    end

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat_o;
endmodule

// File: tb/tb_gpio_wb.sv
// Self-checking bench for gpio_wb: directed register-map steps followed by randomized transfers.
module tb_gpio_wb;
    localparam int N = 20;
`ifdef GPIO_INPUT_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic         wb_clk_i;
    logic         wb_rst_i;
    wire  [N-1:0] gpio_io;
    logic [N-1:0] ext_val;
    logic [N-1:0] ext_en;

    gpio_wb_if wb ();

    gpio_wb #(.N(N)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wb       (wb),
        .gpio_io  (gpio_io)
    );

    // External world: drives every pin the DUT is not supposed to drive.
    for (genvar g = 0; g < N; g++) begin : g_ext
        assign gpio_io[g] = ext_en[g] ? ext_val[g] : 1'bz;
    end

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Reference model state
    logic [N-1:0] m_latch;
    logic [N-1:0] m_oe;
    logic [31:0]  exp_rdata;
    logic [N-1:0] pin_hist[$];
    int           n_checks;
    int           n_pass;
    int           n_fail;

    assign ext_en = ~m_oe;

    function automatic logic [N-1:0] model_pins();
        return (m_oe & m_latch) | (~m_oe & ext_val);
    endfunction

    // Pin level seen at each rising edge; synchronizer flops hold zero while in reset.
    always @(posedge wb_clk_i) begin
        pin_hist.push_back(wb_rst_i ? model_pins() : '0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic model_reset();
        m_latch   = '0;
        m_oe      = '0;
        exp_rdata = '0;
    endtask

    task automatic model_write(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] lane;
        logic [N-1:0] m;
        logic [N-1:0] d;
        lane = '0;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) lane[8*k +: 8] = 8'hFF;
        end
        m = lane[N-1:0];
        d = dat[N-1:0] & m;
        case (adr)
            2'd0: m_latch = (m_latch & ~m) | d;
            2'd1: m_oe    = (m_oe & ~m) | d;
            2'd2: m_latch = m_latch | d;
            default: m_latch = m_latch & ~d;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] adr, input int e);
        logic [31:0] r;
        r = '0;
        if (adr == 2'd0) begin
            if (SYNC) r[N-1:0] = (e >= 2) ? pin_hist[e-2] : '0;
            else      r[N-1:0] = pin_hist[e];
        end else if (adr == 2'd1) begin
            r[N-1:0] = m_oe;
        end
        return r;
    endfunction

    // Called just after a rising edge (+1); returns in the same phase.
    task automatic xfer(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input string tag);
        int n;
        int e;
        wb.wb_we_i  = we;
        wb.wb_adr_i = adr;
        wb.wb_dat_i = dat;
        wb.wb_sel_i = sel;
        wb.wb_stb_i = 1'b1;
        n = 0;
        do begin
            @(posedge wb_clk_i);
            #1;
            n++;
        end while (wb.wb_ack_o !== 1'b1 && n < 8);
        check({tag, "_ack_latency"}, n, 1);
        e = pin_hist.size() - 1;
        if (we) model_write(adr, dat, sel);
        else    exp_rdata = model_read(adr, e);
        check({tag, "_dat_o"}, wb.wb_dat_o, exp_rdata);
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        @(posedge wb_clk_i);
        #1;
        check({tag, "_ack_clear"}, {31'd0, wb.wb_ack_o}, 32'd0);
    endtask

    task automatic check_pins(input string tag);
        check(tag, {{(32-N){1'b0}}, gpio_io}, {{(32-N){1'b0}}, model_pins()});
    endtask

    initial begin
        logic [31:0] rdat;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        wb.wb_adr_i = '0;
        wb.wb_dat_i = '0;
        wb.wb_we_i  = 1'b0;
        wb.wb_sel_i = '0;
        wb.wb_stb_i = 1'b0;
        ext_val  = N'($urandom);
        wb_rst_i = 1'b0;
        model_reset();

        // Reset held: no ack, zero read data, pins left to the outside world.
        idle(4);
        check("rst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
        check("rst_dat_o", wb.wb_dat_o, 32'd0);
        check_pins("rst_pins_undriven");
        wb_rst_i = 1'b1;
        idle(2);
        xfer(1'b0, 2'd1, '0, 4'hF, "rd_oe_after_rst");
        check("oe_after_rst_const", wb.wb_dat_o, 32'h0);

        // Drive DATA with pull-ups on the undriven pins.
        ext_val = '1;
        xfer(1'b1, 2'd1, 32'h0000000F, 4'hF, "wr_oe_f");
        xfer(1'b1, 2'd0, 32'h000000A5, 4'hF, "wr_data_a5");
        check_pins("pins_a5");
        check("pins_a5_const", {24'd0, gpio_io[7:0]}, 32'h000000F5);
        idle(3);
        xfer(1'b0, 2'd0, '0, 4'hF, "rd_data_f5");
        check("rd_data_f5_const", wb.wb_dat_o, 32'h000FFFF5);

        // SET / CLR on a latch of 0x0F, observed with all pins driven.
        xfer(1'b1, 2'd1, 32'hFFFFFFFF, 4'hF, "wr_oe_all");
        xfer(1'b1, 2'd0, 32'h0000000F, 4'hF, "wr_data_0f");
        xfer(1'b1, 2'd2, 32'h00000030, 4'hF, "wr_set_30");
        check("pins_3f_const", {12'd0, gpio_io}, 32'h0000003F);
        xfer(1'b1, 2'd3, 32'h00000005, 4'hF, "wr_clr_05");
        check("pins_3a_const", {12'd0, gpio_io}, 32'h0000003A);
        xfer(1'b0, 2'd2, '0, 4'hF, "rd_set");
        check("rd_set_const", wb.wb_dat_o, 32'h0);
        xfer(1'b0, 2'd3, '0, 4'hF, "rd_clr");

        // Byte lanes; lane 2 only reaches pins [19:16].
        xfer(1'b1, 2'd0, 32'h11223344, 4'hF, "wr_data_lanes_all");
        xfer(1'b1, 2'd0, 32'hAABBCCDD, 4'b0101, "wr_data_lanes_0101");
        check("pins_lanes_const", {12'd0, gpio_io}, 32'h000B33DD);
        xfer(1'b0, 2'd1, '0, 4'b0000, "rd_oe_sel_ignored");
        check("rd_oe_all_const", wb.wb_dat_o, 32'h000FFFFF);

        // Held strobe: ack on every other edge.
        wb.wb_we_i  = 1'b0;
        wb.wb_adr_i = 2'd1;
        wb.wb_stb_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge wb_clk_i);
            #1;
            check("held_stb_ack", {31'd0, wb.wb_ack_o}, {31'd0, (i % 2 == 0)});
        end
        wb.wb_stb_i = 1'b0;
        idle(1);

        // Input synchronizer latency: toggle a pin k cycles before a DATA read.
        xfer(1'b1, 2'd1, 32'h0, 4'hF, "wr_oe_none");
        for (int k = 0; k < 4; k++) begin
            ext_val = '0;
            idle(4);
            ext_val[0] = 1'b1;
            idle(k);
            xfer(1'b0, 2'd0, '0, 4'hF, "rd_toggle");
            check("toggle_bit0", {31'd0, wb.wb_dat_o[0]}, {31'd0, (!SYNC || k >= 2)});
        end

        // Reset asserted between strobe and ack loses the write.
        xfer(1'b1, 2'd1, 32'hFFFFFFFF, 4'hF, "wr_oe_all2");
        xfer(1'b1, 2'd0, 32'h0, 4'hF, "wr_data_zero");
        wb.wb_we_i  = 1'b1;
        wb.wb_adr_i = 2'd0;
        wb.wb_dat_i = 32'hFFFFFFFF;
        wb.wb_sel_i = 4'hF;
        wb.wb_stb_i = 1'b1;
        #2;
        wb_rst_i = 1'b0;
        model_reset();
        @(posedge wb_clk_i);
        #1;
        check("midrst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        idle(1);
        wb_rst_i = 1'b1;
        idle(2);
        check("midrst_no_ack_after", {31'd0, wb.wb_ack_o}, 32'd0);
        check_pins("midrst_pins_undriven");
        xfer(1'b1, 2'd1, 32'hFFFFFFFF, 4'hF, "wr_oe_post_rst");
        check("midrst_latch_zero", {12'd0, gpio_io}, 32'h0);

        // Randomized transfers against the model.
        for (int t = 0; t < 60; t++) begin
            logic        we;
            logic [1:0]  adr;
            logic [31:0] dat;
            logic [3:0]  sel;
            ext_val = N'($urandom);
            idle($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1));
            adr = 2'($urandom_range(0, 3));
            dat = $urandom;
            sel = 4'($urandom_range(0, 15));
            xfer(we, adr, dat, sel, "rand");
            check_pins("rand_pins");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/gpio_wb.md
Name: gpio_wb

Overview:
- Wishbone-slave general-purpose I/O block for the Hydrogen SoC.
- Sits behind the SoC interconnect, which decodes the GPIO address window and drives wb_stb_i.
- Provides N bidirectional pins, each with a per-bit output-enable, a data latch, and atomic set/clear registers.

Parameters:
- N, 8, number of GPIO pins (1..32). Register bits [31:N] are read-only and read as 0.

Ports:
- wb_clk_i  input  1  single system clock; all state changes on the rising edge.
- wb_rst_i  input  1  reset, asynchronous and active-low (0 = reset).
- wb_adr_i  input  2  word address within the block (bus address bits [3:2]).
- wb_dat_i  input  32  write data.
- wb_dat_o  output  32  read data, registered.
- wb_we_i  input  1  1 = write, 0 = read.
- wb_sel_i  input  4  byte-lane enables; bit k qualifies bits [8k+7:8k].
- wb_stb_i  input  1  strobe, already qualified with cyc by the interconnect.
- wb_ack_o  output  1  transfer acknowledge, registered.
- gpio_io  inout  N  pins.

Behaviour:
- Register map (word index on wb_adr_i):
  - 0 DATA: write updates the output latch; read returns the sampled pin values.
  - 1 OE: per-bit output enable; 1 = drive the pin; read returns OE.
  - 2 SET: each written 1 sets the matching latch bit; reads 0.
  - 3 CLR: each written 1 clears the matching latch bit; reads 0.
- Pin drive: gpio_io[i] = latch[i] when OE[i] = 1, otherwise high-Z.
- Reset (wb_rst_i = 0, asynchronous): latch = 0, OE = 0 (all pins high-Z), wb_ack_o = 0, wb_dat_o = 0, synchronizer flops = 0.
- Handshake: on a rising edge where wb_stb_i = 1 and wb_ack_o = 0, the access is performed and wb_ack_o is set to 1 for exactly one cycle. wb_ack_o is cleared on the next edge.
- Latency and throughput:
  - Latency is 1 cycle.
  - A master holding stb continuously gets one ack every 2 cycles.
  - stb deasserted before ack aborts the access with no side effects.
- Writes commit on the acknowledging edge. Only byte lanes with wb_sel_i[k] = 1 are affected, for DATA, OE, SET and CLR alike.
- Reads:
  - wb_dat_o is loaded on the acknowledging edge and holds its value until the next read ack.
  - wb_dat_o is not changed by writes.
  - wb_sel_i is ignored on reads; the full word is returned.
- DATA read value: bit i is the (optionally synchronized) pin level, whether the pin is an input or an output. A driven pin therefore reads back its latch value after the synchronizer latency.
- Bits [31:N] of all registers are ignored on write and read as 0.
- Reset asserted mid-transfer: ack drops immediately and the pending write is lost. After release, no access occurs until the first edge with stb = 1.

Optional Feature:
- Macro: GPIO_INPUT_SYNC_EN.
- Defined: pin inputs pass through a 2-flop synchronizer. A DATA read reflects the pin level from 2 cycles before the acknowledging edge.
- Undefined: a DATA read samples gpio_io directly on the acknowledging edge, with no extra latency.
- Register map and handshake are identical in both builds.

Test Plan:
- Reset: hold wb_rst_i = 0 -> wb_ack_o = 0, wb_dat_o = 0, all gpio_io = Z. Read OE after release -> 0x00000000.
- Drive DATA: write OE = 0x0000000F, then DATA = 0x000000A5, sel = 4'b1111 -> pins[3:0] = 4'b0101, pins[7:4] = Z. Read DATA with external pull-ups on [7:4] -> 0x000000F5.
- Set/clear: latch = 0x0F; write SET = 0x30 -> latch 0x3F; write CLR = 0x05 -> latch 0x3A. Reads of SET/CLR -> 0.
- Byte lanes (N = 32): OE = 0xFFFFFFFF; DATA = 0x11223344; write 0xAABBCCDD with sel = 4'b0101 -> latch 0x11BB33DD.
- Handshake: stb held high with no gaps -> ack pattern 0,1,0,1 across edges. stb pulsed one cycle for a write -> exactly one ack and one commit.
- Async reset mid-access: assert reset between stb and ack -> ack never asserts, latch stays 0. With GPIO_INPUT_SYNC_EN, an input pin toggled to 1 reads 1 only when the toggle precedes the ack edge by 2 or more cycles.
